// File: rtl/beta_fetch_unit.sv
// Decoupled Beta instruction-fetch front end: fetch PC, one in-flight memory request, prefetch FIFO.
// Optional user-mode interrupt path enabled by defining FETCH_IRQ_EN.
module beta_fetch_unit #(
   parameter int unsigned       XLEN      = 32,
   parameter int unsigned       BUF_DEPTH = 2,
   parameter logic [XLEN-1:0]   RESET_VEC = 32'h0000_0000,
   parameter logic [XLEN-1:0]   ILLOP_VEC = 32'h0000_0004,
   parameter logic [XLEN-1:0]   XADR_VEC  = 32'h0000_0008
) (
   input  logic            clk,
   input  logic            RESET,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            redir_valid,
   input  logic [2:0]      PCSEL,
   input  logic [XLEN-1:0] BRTGT,
   input  logic [XLEN-1:0] JT,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc4
`ifdef FETCH_IRQ_EN
   ,
   input  logic            IRQ,
   output logic            irq_taken,
   output logic [XLEN-1:0] irq_save_pc
`endif
);

   localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned OW = AW + 2;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_pc;
   logic            outstanding;
   logic            discard;

   logic [31:0]     fifo_instr [BUF_DEPTH];
   logic [XLEN-1:0] fifo_pc    [BUF_DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_next;
   logic [CW-1:0]   count;

   logic            redirect;
   logic            irq_take;
   logic            flush;
   logic            pop;
   logic            resp_live;
   logic            push;
   logic            out_after;
   logic            inflight_after;
   logic            can_issue;
   logic            issue;
   logic [OW-1:0]   occ;
   logic [XLEN-1:0] redir_pc;
   logic [XLEN-1:0] flush_pc;
   logic [XLEN-1:0] save_pc;

   logic unused_bits;
   assign unused_bits = ^{BRTGT[XLEN-1], BRTGT[1:0], JT[1:0]};

   assign id_valid  = (count != '0);
   assign id_instr  = fifo_instr[rd_ptr];
   assign id_pc     = fifo_pc[rd_ptr];
   assign id_pc4    = {id_pc[XLEN-1], id_pc[XLEN-2:0] + (XLEN-1)'(4)};
   assign imem_addr = {1'b0, fetch_pc[XLEN-2:2], 2'b00};
   assign imem_req  = issue;
   assign rd_next   = rd_ptr + AW'(1);

   always_comb begin
      redirect  = redir_valid && (PCSEL != 3'd0);
      irq_take  = 1'b0;
`ifdef FETCH_IRQ_EN
      irq_take  = IRQ && !fetch_pc[XLEN-1] && !RESET && !redirect;
`endif
      flush     = redirect || irq_take;
      pop       = id_valid && id_ready;
      resp_live = imem_rvalid && !discard;
      push      = resp_live && !flush && !RESET;
      out_after = outstanding && !resp_live;
      inflight_after = (outstanding || discard) && !imem_rvalid;
      // Occupancy counts this cycle's push and pop so a full FIFO never receives a response.
      occ       = OW'(count) + OW'(push) + OW'(out_after) - OW'(pop);
      can_issue = (!outstanding && !discard) || imem_rvalid;
      issue     = !RESET && !flush && can_issue && (occ < OW'(BUF_DEPTH));

      redir_pc = {1'b1, ILLOP_VEC[XLEN-2:0]};
      unique case (PCSEL)
         3'd1:    redir_pc = {fetch_pc[XLEN-1], BRTGT[XLEN-2:2], 2'b00};
         3'd2:    redir_pc = {fetch_pc[XLEN-1] & JT[XLEN-1], JT[XLEN-2:2], 2'b00};
         3'd4:    redir_pc = {1'b1, XADR_VEC[XLEN-2:0]};
         default: redir_pc = {1'b1, ILLOP_VEC[XLEN-2:0]};
      endcase
      flush_pc = redirect ? redir_pc : {1'b1, XADR_VEC[XLEN-2:0]};

      // Oldest instruction not yet handed to decode.
      if (count > CW'(pop))
         save_pc = pop ? fifo_pc[rd_next] : fifo_pc[rd_ptr];
      else if (outstanding)
         save_pc = req_pc;
      else
         save_pc = fetch_pc;
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         fetch_pc    <= {1'b1, RESET_VEC[XLEN-2:0]};
         req_pc      <= '0;
         outstanding <= 1'b0;
         discard     <= inflight_after;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (flush) begin
         fetch_pc    <= flush_pc;
         outstanding <= 1'b0;
         discard     <= inflight_after;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else begin
         if (issue) begin
            fetch_pc    <= {fetch_pc[XLEN-1], fetch_pc[XLEN-2:0] + (XLEN-1)'(4)};
            req_pc      <= fetch_pc;
            outstanding <= 1'b1;
         end else if (resp_live) begin
            outstanding <= 1'b0;
         end
         if (discard && imem_rvalid)
            discard <= 1'b0;
         if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= req_pc;
            wr_ptr             <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_next;
         count <= count + CW'(push) - CW'(pop);
      end
   end

`ifdef FETCH_IRQ_EN
   always_ff @(posedge clk) begin
      if (RESET) begin
         irq_taken   <= 1'b0;
         irq_save_pc <= '0;
      end else begin
         irq_taken <= irq_take;
         if (irq_take)
            irq_save_pc <= save_pc;
      end
   end
`else
   logic unused_save;
   assign unused_save = ^save_pc;
`endif

endmodule

// File: tb/tb_beta_fetch_unit.sv
// Directed self-checking bench for beta_fetch_unit with a pipelined fixed-latency memory model
// (instruction word = address >> 2). IRQ steps build only when FETCH_IRQ_EN is defined.
module tb_beta_fetch_unit;

   logic        clk = 1'b0;
   logic        RESET;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redir_valid;
   logic [2:0]  PCSEL;
   logic [31:0] BRTGT;
   logic [31:0] JT;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
`ifdef FETCH_IRQ_EN
   logic        IRQ;
   logic        irq_taken;
   logic [31:0] irq_save_pc;
`endif

   int          checks = 0;
   int          failures = 0;
   int          lat = 1;
   int          nreq = 0;
   bit [3:0]    pv = '0;
   logic [31:0] pa [4];

   beta_fetch_unit #(
      .XLEN(32),
      .BUF_DEPTH(2)
   ) dut (
      .clk(clk),
      .RESET(RESET),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
      .redir_valid(redir_valid),
      .PCSEL(PCSEL),
      .BRTGT(BRTGT),
      .JT(JT),
      .id_valid(id_valid),
      .id_ready(id_ready),
      .id_instr(id_instr),
      .id_pc(id_pc),
      .id_pc4(id_pc4)
`ifdef FETCH_IRQ_EN
      ,
      .IRQ(IRQ),
      .irq_taken(irq_taken),
      .irq_save_pc(irq_save_pc)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock: sample the request, advance the memory pipe, return at the next negedge.
   task automatic tick();
      logic        r;
      logic [31:0] a;
      #1;
      r = imem_req;
      a = imem_addr;
      if (r === 1'b1) nreq++;
      @(posedge clk);
      for (int i = 3; i > 0; i--) begin
         pv[i] = pv[i-1];
         pa[i] = pa[i-1];
      end
      pv[0] = r;
      pa[0] = a;
      #1;
      imem_rvalid = pv[lat-1];
      imem_rdata  = pa[lat-1] >> 2;
      @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      #1;
      while (id_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
         #1;
      end
      chk1(tag, id_valid, 1'b1);
   endtask

   task automatic redir(input logic [2:0] sel, input logic [31:0] br, input logic [31:0] jt);
      redir_valid = 1'b1;
      PCSEL = sel;
      BRTGT = br;
      JT = jt;
      tick();
      redir_valid = 1'b0;
      PCSEL = 3'd0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 4; i++) pa[i] = '0;
      RESET = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      redir_valid = 1'b0; PCSEL = 3'd0; BRTGT = '0; JT = '0; id_ready = 1'b0;
`ifdef FETCH_IRQ_EN
      IRQ = 1'b0;
`endif
      tick();
      tick();
      #1;
      chk1("reset_req", imem_req, 1'b0);
      chk1("reset_valid", id_valid, 1'b0);
`ifdef FETCH_IRQ_EN
      chk1("reset_irq_taken", irq_taken, 1'b0);
      chk("reset_irq_save_pc", irq_save_pc, 32'h0);
`endif

      // 1-cycle memory, streaming
      RESET = 1'b0; id_ready = 1'b1; #1;
      chk1("c0_req", imem_req, 1'b1);
      chk("c0_addr", imem_addr, 32'h0000_0000);
      tick(); #1;
      chk1("c1_valid", id_valid, 1'b0);
      chk("c1_addr", imem_addr, 32'h0000_0004);
      tick();
      for (int i = 0; i < 3; i++) begin
         #1;
         chk1("stream_valid", id_valid, 1'b1);
         chk("stream_pc", id_pc, 32'h8000_0000 + 32'(4 * i));
         chk("stream_instr", id_instr, 32'(i));
         if (i == 0) chk("stream_pc4", id_pc4, 32'h8000_0004);
         tick();
      end

      // Back-pressure: FIFO fills, requests stop
      id_ready = 1'b0; nreq = 0;
      repeat (10) tick();
      #1;
      chk("stall_nreq", nreq, 32'd0);
      chk1("stall_req", imem_req, 1'b0);
      chk1("stall_valid", id_valid, 1'b1);
      chk("stall_head", id_pc, 32'h8000_000C);
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk1("release_valid", id_valid, 1'b1);
         chk("release_pc", id_pc, 32'h8000_000C + 32'(4 * i));
         chk("release_instr", id_instr, 32'(3 + i));
         tick();
      end

      // Quiesce, then 3-cycle memory and a branch one cycle after a request
      id_ready = 1'b0;
      repeat (5) tick();
      #1;
      chk1("quiet_req", imem_req, 1'b0);
      chk("quiet_head", id_pc, 32'h8000_001C);
      lat = 3; id_ready = 1'b1; #1;
      chk1("d0_req", imem_req, 1'b1);
      chk("d0_addr", imem_addr, 32'h0000_0024);
      tick();
      redir_valid = 1'b1; PCSEL = 3'd1; BRTGT = 32'h0000_0100; #1;
      chk1("redir_no_req", imem_req, 1'b0);
      chk("redir_hs_pc", id_pc, 32'h8000_0020);
      tick();
      redir_valid = 1'b0; PCSEL = 3'd0; #1;
      chk1("flushed_valid", id_valid, 1'b0);
      chk1("discard_no_req", imem_req, 1'b0);
      wait_valid("br_wait");
      chk("br_pc", id_pc, 32'h8000_0100);
      chk("br_instr", id_instr, 32'h0000_0040);
      chk("br_pc4", id_pc4, 32'h8000_0104);

      // JMP cannot raise privilege; PCSEL 5-7 behaves as ILLOP
      redir(3'd2, 32'h0, 32'h0000_0040);
      wait_valid("jmp_user_wait");
      chk("jmp_user_pc", id_pc, 32'h0000_0040);
      chk("jmp_user_pc4", id_pc4, 32'h0000_0044);
      redir(3'd2, 32'h0, 32'h8000_0200);
      wait_valid("jmp_sup_wait");
      chk("jmp_sup_pc", id_pc, 32'h0000_0200);
      chk("jmp_sup_instr", id_instr, 32'h0000_0080);
      redir(3'd7, 32'h0, 32'h0);
      wait_valid("illop_wait");
      chk("illop_pc", id_pc, 32'h8000_0004);
      chk("illop_instr", id_instr, 32'h0000_0001);
      redir(3'd0, 32'h0000_0300, 32'h0000_0300);
      wait_valid("nop_redir_wait");
      chk("nop_redir_pc", id_pc, 32'h8000_0008);

`ifdef FETCH_IRQ_EN
      redir(3'd2, 32'h0, 32'h0000_0010);
      wait_valid("irq_setup_wait");
      chk("irq_head_pc", id_pc, 32'h0000_0010);
      id_ready = 1'b0; IRQ = 1'b1;
      tick();
      IRQ = 1'b0; #1;
      chk1("irq_pulse", irq_taken, 1'b1);
      chk("irq_save", irq_save_pc, 32'h0000_0010);
      tick(); #1;
      chk1("irq_pulse_end", irq_taken, 1'b0);
      id_ready = 1'b1;
      wait_valid("irq_vec_wait");
      chk("irq_vec_pc", id_pc, 32'h8000_0008);
      chk("irq_vec_instr", id_instr, 32'h0000_0002);
      IRQ = 1'b1;
      tick(); #1;
      chk1("irq_sup_ignored", irq_taken, 1'b0);
      wait_valid("irq_sup_wait");
      chk("irq_sup_next_pc", id_pc, 32'h8000_000C);
      IRQ = 1'b0;
`endif

      // RESET while a request is in flight
      n = 0;
      #1;
      while (imem_req !== 1'b1 && n < 40) begin
         tick();
         n++;
         #1;
      end
      chk1("pre_reset_req", imem_req, 1'b1);
      tick();
      RESET = 1'b1; #1;
      chk1("mid_reset_req", imem_req, 1'b0);
      tick();
      RESET = 1'b0;
      wait_valid("post_reset_wait");
      chk("post_reset_pc", id_pc, 32'h8000_0000);
      chk("post_reset_instr", id_instr, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/beta_fetch_unit.md
Name: beta_fetch_unit

Overview:
- Parametrised, decoupled instruction-fetch front end for the Beta core; successor to the single-cycle PC/PCSEL/RESET logic.
- Owns the fetch PC and supervisor bit, issues requests to an instruction memory with variable latency, and buffers returned words in a prefetch FIFO.
- Hands {instruction, PC, PC+4} to decode over a valid/ready handshake.
- Handles redirects (branch, JMP, ILLOP, XADR) and user-mode IRQ with flush of stale fetches.

Parameters:
- XLEN, 32, PC/address width; bit XLEN-1 is the supervisor bit.
- BUF_DEPTH, 2, prefetch FIFO entries (power of two, >=2).
- RESET_VEC, 0x00000000, reset target (low XLEN-1 bits).
- ILLOP_VEC, 0x00000004, illegal-op target.
- XADR_VEC, 0x00000008, interrupt target.

Ports:
- clk  in  1  clock
- RESET  in  1  synchronous active-high reset
- imem_req  out  1  fetch request; memory accepts every cycle it is high
- imem_addr  out  XLEN  word address {1'b0, pc[XLEN-2:2], 2'b00}
- imem_rvalid  in  1  response valid, in order, >=1 cycle after request
- imem_rdata  in  32  instruction word
- redir_valid  in  1  redirect strobe from execute
- PCSEL  in  3  0 none, 1 branch, 2 JMP, 3 ILLOP, 4 XADR, 5-7 treated as ILLOP
- BRTGT  in  XLEN  branch target (PC4+4*SXTC)
- JT  in  XLEN  jump target (RD1)
- id_valid  out  1  decode slot valid
- id_ready  in  1  decode accepts
- id_instr  out  32  instruction
- id_pc  out  XLEN  instruction PC including supervisor bit
- id_pc4  out  XLEN  id_pc+4, supervisor bit preserved
- irq_taken  out  1  one-cycle pulse (FETCH_IRQ_EN only)
- irq_save_pc  out  XLEN  PC to save in XP (FETCH_IRQ_EN only)

Behaviour:
- Reset:
  - fetch_pc = {1'b1, RESET_VEC[XLEN-2:0]}; FIFO empty; outstanding=0; discard=0.
  - imem_req=0, id_valid=0, irq_taken=0; irq_save_pc=0.
  - RESET mid-transaction drops any pending response: discard is set if outstanding was 1.
- Request issue:
  - imem_req=1 when all hold: no RESET, no redirect, no IRQ take, (outstanding==0 or imem_rvalid), and fifo_count + outstanding_after < BUF_DEPTH.
  - On issue: fetch_pc += 4, wrapping modulo 2^(XLEN-1) within the low bits; bit XLEN-1 is unchanged. Record req_pc.
- Response:
  - imem_rvalid with discard=0 pushes {imem_rdata, req_pc} and clears outstanding.
  - imem_rvalid with discard=1 is dropped and clears discard.
- Decode handshake:
  - id_valid = FIFO non-empty; outputs are the FIFO head.
  - Pop on id_valid & id_ready.
  - Push and pop in the same cycle are legal, including when the FIFO is full.
  - Throughput is 1 instr/cycle with 1-cycle memory.
- Redirect (redir_valid & PCSEL!=0):
  - Takes effect next cycle: flush FIFO; set discard if a request is outstanding and no rvalid arrives this cycle; no imem_req this cycle.
  - A handshake in the same cycle still completes.
  - New fetch_pc:
    - Branch: {sup, BRTGT[XLEN-2:2], 00}.
    - JMP: {sup & JT[XLEN-1], JT[XLEN-2:2], 00}; a JMP can never enter supervisor mode.
    - ILLOP / XADR: {1'b1, vector}.
  - sup = current fetch_pc[XLEN-1].
  - Priority: RESET > redirect > IRQ.
- redir_valid with PCSEL=0: no effect.

Optional Feature:
- Macro: FETCH_IRQ_EN.
- When defined: if IRQ=1, fetch_pc[XLEN-1]==0, and there is no RESET and no redirect, the IRQ is taken:
  - Same flush/discard as a redirect; fetch_pc = {1'b1, XADR_VEC}.
  - irq_taken pulses next cycle.
  - irq_save_pc = PC of the oldest undelivered instruction: FIFO head (excluding one popped this cycle), else the outstanding req_pc, else fetch_pc.
  - IRQ is ignored in supervisor mode.
- When undefined: IRQ, irq_taken and irq_save_pc are absent; no interrupt path exists.

Test Plan:
- Reset, 1-cycle memory returning addr>>2, id_ready=1 -> id_pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; id_instr 0,1,2.
- id_ready=0 for 10 cycles -> FIFO holds 2 entries; imem_req low after 2 issues; release -> delivers in order, no gaps or duplicates.
- 3-cycle memory latency; redir_valid PCSEL=1 BRTGT=0x00000100 one cycle after a request -> late response dropped; next id_pc 0x80000100.
- From user PC 0x00000040, JMP with JT=0x80000200 -> id_pc 0x00000200 (supervisor bit stays clear); PCSEL=7 -> id_pc 0x80000004.
- FETCH_IRQ_EN: user mode with FIFO head pc 0x00000010; IRQ=1 -> irq_taken pulse, irq_save_pc 0x00000010, next id_pc 0x80000008; repeat IRQ in supervisor -> ignored.
- RESET asserted while a request is outstanding -> stale rvalid discarded; first id_pc 0x80000000.
